accum_seq_ctrl: RTL and testbench

- Sequencer for the n-bit accumulator datapath (adder_nbits feeding a WIDTH-bit register).
- Accepts a job of len_i operands and streams them in over a valid/ready handshake, adding each into the register.
- Presents the final sum and sticky carry with a valid/ack handshake.
- Sits between an operand producer and the consumer of the reduced result.

---
 rtl/accum_seq_ctrl.sv | 92 +++++++++
 tb/tb_accum_seq_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/accum_seq_ctrl.sv
// Job sequencer for the WIDTH-bit accumulator: takes len_i operands over valid/ready,
// sums them with a sticky carry, and holds the result until the consumer acknowledges it.
module accum_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [CNT_W-1:0] len_i,
   output logic             busy_o,
   input  logic             x_valid_i,
   input  logic [WIDTH-1:0] x_i,
   output logic             x_ready_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             done_o,
   input  logic             done_ack_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CNT_W-1:0] remaining;
   logic             beat;
   logic [WIDTH:0]   sum_ext;

   // Unsigned add returning the carry-out in the extra top bit.
   function automatic logic [WIDTH:0] add_with_carry(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
      return {1'b0, a} + {1'b0, b};
   endfunction

   assign x_ready_o = (state == ACCUM);
   assign done_o    = (state == DONE);
   assign busy_o    = (state != IDLE);
   assign sum_o     = acc;
   assign carry_o   = carry;

   assign beat    = x_valid_i && x_ready_o;
   assign sum_ext = add_with_carry(acc, x_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state     <= IDLE;
         acc       <= '0;
         carry     <= 1'b0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_i) begin
                  acc   <= '0;
                  carry <= 1'b0;
                  if (len_i != '0) begin
                     remaining <= len_i;
                     state     <= ACCUM;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc       <= sum_ext[WIDTH-1:0];
                  carry     <= carry | sum_ext[WIDTH];
                  remaining <= remaining - 1'b1;
                  // The last operand of the job moves straight to DONE.
                  if (remaining == CNT_W'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               if (done_ack_i) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed bench for accum_seq_ctrl: a per-cycle vector table plus hand-written
// sequences for async reset mid-job and the maximum job length.
module tb_accum_seq_ctrl;

   localparam int WIDTH = 32;
   localparam int CNT_W = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             busy;
   logic             x_valid;
   logic [WIDTH-1:0] x;
   logic             x_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             done;
   logic             done_ack;

   int n_cmp = 0;
   int n_err = 0;

   accum_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .len_i      (len),
      .busy_o     (busy),
      .x_valid_i  (x_valid),
      .x_i        (x),
      .x_ready_o  (x_ready),
      .sum_o      (sum),
      .carry_o    (carry),
      .done_o     (done),
      .done_ack_i (done_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic             start;
      logic [CNT_W-1:0] len;
      logic             xv;
      logic [WIDTH-1:0] x;
      logic             ack;
      logic             e_ready;
      logic             e_done;
      logic             e_busy;
      logic [WIDTH-1:0] e_sum;
      logic             e_carry;
   } vec_t;

   vec_t vecs[$];

   function automatic void v(input logic st, input int ln, input logic xv, input logic [WIDTH-1:0] xd,
                             input logic ak, input logic er, input logic ed, input logic eb,
                             input logic [WIDTH-1:0] es, input logic ec);
      vec_t r;
      r.start = st; r.len = CNT_W'(ln); r.xv = xv; r.x = xd; r.ack = ak;
      r.e_ready = er; r.e_done = ed; r.e_busy = eb; r.e_sum = es; r.e_carry = ec;
      vecs.push_back(r);
   endfunction

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic er, input logic ed, input logic eb,
                             input logic [WIDTH-1:0] es, input logic ec);
      check({tag, ".x_ready"}, WIDTH'(x_ready), WIDTH'(er));
      check({tag, ".done"},    WIDTH'(done),    WIDTH'(ed));
      check({tag, ".busy"},    WIDTH'(busy),    WIDTH'(eb));
      check({tag, ".sum"},     sum,             es);
      check({tag, ".carry"},   WIDTH'(carry),   WIDTH'(ec));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input int ln, input logic xv, input logic [WIDTH-1:0] xd,
                        input logic ak);
      start = st; len = CNT_W'(ln); x_valid = xv; x = xd; done_ack = ak;
   endtask

   initial begin
      int beats;
      rst = 1'b1;
      drive(0, 0, 0, '0, 0);

      // Expected outputs are those seen just after the edge that samples the row's inputs.
      //  start len xv  x             ack  rdy done busy sum           carry
      v(1, 3,   0, 32'd0,         0,   1, 0, 1, 32'd0,         0);  // plan 1
      v(0, 0,   1, 32'd5,         0,   1, 0, 1, 32'd5,         0);
      v(0, 0,   1, 32'd7,         0,   1, 0, 1, 32'd12,        0);
      v(0, 0,   1, 32'd9,         0,   0, 1, 1, 32'd21,        0);
      v(0, 0,   0, 32'd0,         1,   0, 0, 0, 32'd21,        0);
      v(0, 0,   0, 32'd0,         0,   0, 0, 0, 32'd21,        0);
      v(1, 2,   0, 32'd0,         0,   1, 0, 1, 32'd0,         0);  // plan 2
      v(0, 0,   1, 32'hFFFF_FFFF, 0,   1, 0, 1, 32'hFFFF_FFFF, 0);
      v(0, 0,   1, 32'd2,         0,   0, 1, 1, 32'd1,         1);
      v(0, 0,   0, 32'd0,         1,   0, 0, 0, 32'd1,         1);
      v(0, 0,   0, 32'd0,         0,   0, 0, 0, 32'd1,         1);
      v(1, 1,   0, 32'd0,         0,   1, 0, 1, 32'd0,         0);
      v(0, 0,   1, 32'd4,         0,   0, 1, 1, 32'd4,         0);
      v(0, 0,   0, 32'd0,         1,   0, 0, 0, 32'd4,         0);
      v(0, 0,   0, 32'd0,         0,   0, 0, 0, 32'd4,         0);
      v(1, 0,   0, 32'd0,         0,   0, 1, 1, 32'd0,         0);  // plan 3
      v(0, 0,   0, 32'd0,         1,   0, 0, 0, 32'd0,         0);
      v(0, 0,   0, 32'd0,         0,   0, 0, 0, 32'd0,         0);
      v(1, 4,   0, 32'd0,         0,   1, 0, 1, 32'd0,         0);  // plan 4
      v(0, 0,   1, 32'd1,         0,   1, 0, 1, 32'd1,         0);
      v(0, 0,   0, 32'd99,        0,   1, 0, 1, 32'd1,         0);
      v(0, 0,   0, 32'd99,        0,   1, 0, 1, 32'd1,         0);
      v(0, 0,   1, 32'd2,         0,   1, 0, 1, 32'd3,         0);
      v(0, 0,   1, 32'd3,         0,   1, 0, 1, 32'd6,         0);
      v(0, 0,   0, 32'd50,        0,   1, 0, 1, 32'd6,         0);
      v(0, 0,   1, 32'd4,         0,   0, 1, 1, 32'd10,        0);
      v(1, 7,   1, 32'd100,       0,   0, 1, 1, 32'd10,        0);  // plan 5
      v(0, 0,   1, 32'd100,       0,   0, 1, 1, 32'd10,        0);
      v(1, 5,   0, 32'd0,         0,   0, 1, 1, 32'd10,        0);
      v(0, 0,   0, 32'd0,         0,   0, 1, 1, 32'd10,        0);
      v(1, 3,   0, 32'd0,         0,   0, 1, 1, 32'd10,        0);
      v(1, 5,   0, 32'd0,         1,   0, 0, 0, 32'd10,        0);
      v(0, 0,   0, 32'd0,         0,   0, 0, 0, 32'd10,        0);
      v(1, 1,   0, 32'd0,         0,   1, 0, 1, 32'd0,         0);
      v(0, 0,   1, 32'd8,         0,   0, 1, 1, 32'd8,         0);
      v(0, 0,   0, 32'd0,         1,   0, 0, 0, 32'd8,         0);

      #12;
      check_outs("reset", 0, 0, 0, '0, 0);
      @(negedge clk);
      rst = 1'b0;
      step();
      check_outs("post_reset", 0, 0, 0, '0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].start, int'(vecs[i].len), vecs[i].xv, vecs[i].x, vecs[i].ack);
         step();
         check_outs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_done, vecs[i].e_busy,
                    vecs[i].e_sum, vecs[i].e_carry);
      end
      drive(0, 0, 0, '0, 0);
      step();

      // Async reset partway through a 4-beat job.
      drive(1, 4, 0, '0, 0); step();
      drive(0, 0, 1, 32'd1, 0); step();
      drive(0, 0, 1, 32'd2, 0); step();
      check("rst_mid.sum_before", sum, 32'd3);
      #2 rst = 1'b1;
      #1;
      check_outs("rst_mid.async", 0, 0, 0, '0, 0);
      step();
      rst = 1'b0;
      drive(0, 0, 1, 32'd7, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check_outs($sformatf("rst_mid.idle%0d", i), 0, 0, 0, '0, 0);
      end
      drive(1, 1, 0, '0, 0); step();
      drive(0, 0, 1, 32'd9, 0); step();
      check_outs("rst_fresh", 0, 1, 1, 32'd9, 0);
      drive(0, 0, 0, '0, 1); step();
      drive(0, 0, 0, '0, 0); step();

      // Longest job: every beat adds 1, count beats actually handshaken.
      drive(1, 255, 0, '0, 0); step();
      drive(0, 0, 1, 32'd1, 0);
      beats = 0;
      for (int c = 0; c < 400 && !done; c++) begin
         if (x_ready && x_valid) beats++;
         step();
      end
      check("maxlen.done", WIDTH'(done), WIDTH'(1));
      check("maxlen.beats", WIDTH'(beats), WIDTH'(255));
      check("maxlen.sum", sum, 32'd255);
      check("maxlen.carry", WIDTH'(carry), WIDTH'(0));
      drive(0, 0, 0, '0, 1); step();
      check_outs("maxlen.ack", 0, 0, 0, 32'd255, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
